// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline: instruction encodings, PC
// stepping and the fetch-stage state encoding.
package mips_pkg;

    // All-zero word is sll $0,$0,0: the pipeline bubble.
    localparam logic [31:0] INSTR_NOP        = 32'h00000000;
    // Decode recognises this word as HALT.
    localparam logic [31:0] INSTR_HALT       = 32'hFFFFFFFF;
    // Byte distance between consecutive instruction words.
    localparam logic [31:0] PC_INCREMENT     = 32'd4;
    // Default PC after reset.
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h00000000;

    // Fetch stage run state. HALTED is left only through reset.
    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/instruction_memory.sv
// Word-organised instruction memory: asynchronous read, synchronous
// write, no reset so loaded contents survive a pipeline reset.
// Addresses are byte addresses; the low two bits and everything above
// the word index are dropped, so accesses wrap modulo DEPTH.
module instruction_memory #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_write_en,
    input  logic [31:0]      i_write_addr,
    input  logic [WIDTH-1:0] i_write_data,
    input  logic [31:0]      i_read_addr,
    output logic [WIDTH-1:0] o_read_data
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    w_write_index;
    logic [AW-1:0]    w_read_index;
    // Bits outside the word index are deliberately ignored.
    logic             w_unused_addr_bits;

    assign w_write_index      = i_write_addr[AW+1:2];
    assign w_read_index       = i_read_addr[AW+1:2];
    assign w_unused_addr_bits = ^{i_write_addr[31:AW+2], i_write_addr[1:0],
                                  i_read_addr[31:AW+2],  i_read_addr[1:0]};

    // Loader write port; a same-cycle read of this word still sees the old data.
    always_ff @(posedge i_clk) begin
        if (i_write_en) begin
            r_mem[w_write_index] <= i_write_data;
        end
    end

    // Combinational read at the requested address.
    assign o_read_data = r_mem[w_read_index];

endmodule

// File: rtl/instruction_fetch.sv
// IF stage: PC register, instruction memory and the IF/ID latch.
// Update priority on each edge: halted, disabled, halt request, stall,
// jump, sequential. A taken jump still latches the word at the current
// PC (the delay slot) while the PC moves to the target.
module instruction_fetch
    import mips_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_enable,
    input  logic        i_stall,
    input  logic        i_jump,
    input  logic [31:0] i_jump_address,
    input  logic        i_halt,
    input  logic        i_imem_write_en,
    input  logic [31:0] i_imem_write_addr,
    input  logic [31:0] i_imem_write_data,
    output logic [31:0] o_instruction,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_current,
    output logic        o_halted
);

    fetch_state_t r_state;
    fetch_state_t w_state_next;

    logic [31:0] r_pc;
    logic [31:0] r_if_instruction;
    logic [31:0] r_if_pc;

    logic [31:0] w_fetch_word;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_next;
    logic        w_load;

    instruction_memory #(
        .DEPTH (IMEM_DEPTH),
        .WIDTH (32)
    ) u_imem (
        .i_clk        (i_clk),
        .i_write_en   (i_imem_write_en),
        .i_write_addr (i_imem_write_addr),
        .i_write_data (i_imem_write_data),
        .i_read_addr  (r_pc),
        .o_read_data  (w_fetch_word)
    );

    // 32-bit wrap-around is intended.
    assign w_pc_plus4 = r_pc + PC_INCREMENT;

    // Next state, PC and IF/ID load enable, in priority order.
    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_pc_next    = r_pc;
        case (r_state)
            ST_RUN: begin
                if (i_enable) begin
                    if (i_halt) begin
                        // HALT stays resident in ID; nothing behind it enters.
                        w_state_next = ST_HALTED;
                    end else if (!i_stall) begin
                        // A jump during a stall is dropped; decode re-asserts it.
                        w_load    = 1'b1;
                        w_pc_next = i_jump ? i_jump_address : w_pc_plus4;
                    end
                end
            end
            ST_HALTED: begin
                w_state_next = ST_HALTED;
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    // State register; HALTED is sticky until reset.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // PC register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_pc_next;
        end
    end

    // IF/ID latch: word at the current PC and its PC+4.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_if_instruction <= INSTR_NOP;
            r_if_pc          <= 32'h00000000;
        end else if (w_load) begin
            r_if_instruction <= w_fetch_word;
            r_if_pc          <= w_pc_plus4;
        end
    end

    assign o_instruction = r_if_instruction;
    assign o_pc          = r_if_pc;
    assign o_pc_current  = r_pc;
    assign o_halted      = (r_state == ST_HALTED);

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- IF stage of the 5-stage MIPS pipeline, directly upstream of instruction decode.
- Holds the PC and a loader-writable instruction memory.
- Registers {instruction, PC+4} into the IF/ID latch that decode consumes as i_instruction / i_pc.
- Obeys decode's jump redirect, the hazard unit's stall, and decode's HALT detection.
- Branches and jumps use one delay slot: the instruction fetched behind a taken jump is not flushed.

Parameters:
- IMEM_DEPTH, 256, instruction memory size in 32-bit words; power of two.
- RESET_PC, 32'h00000000, PC value after reset.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  reset, asynchronous, active-high.
- i_enable  in  1  run/step enable from the debug unit; 0 freezes the stage.
- i_stall  in  1  load-use stall from the hazard unit.
- i_jump  in  1  taken jump/branch from decode (combinational, same cycle).
- i_jump_address  in  32  jump target from decode.
- i_halt  in  1  HALT present in IF/ID, from decode o_halt.
- i_imem_write_en  in  1  loader word-write strobe.
- i_imem_write_addr  in  32  loader byte address; bits [1:0] ignored.
- i_imem_write_data  in  32  loader word.
- o_instruction  out  32  IF/ID instruction.
- o_pc  out  32  IF/ID PC+4 of that instruction.
- o_pc_current  out  32  live PC register, for debug readout.
- o_halted  out  1  sticky halted flag.

Behaviour:
- Reset (async, any time, including mid-load or mid-run):
  - PC = RESET_PC.
  - o_instruction = 32'h00000000 (NOP).
  - o_pc = 0.
  - o_halted = 0.
  - Memory contents are untouched.
- Memory:
  - Index = addr[log2(IMEM_DEPTH)+1:2]; higher bits are ignored, so addresses wrap modulo depth.
  - Combinational read at the current PC.
  - Synchronous write on i_clk when i_imem_write_en = 1.
  - Same-cycle write and fetch of the same word: fetch gets the old data; the new data is visible next cycle.
  - Writes are accepted in every state, including halted and disabled.
- Per rising edge, the first matching rule applies:
  1. o_halted = 1: PC and IF/ID hold.
  2. i_enable = 0: PC and IF/ID hold; i_halt is ignored.
  3. i_halt = 1: set o_halted; PC and IF/ID hold, so HALT stays resident in ID.
  4. i_stall = 1: PC and IF/ID hold. i_jump in the same cycle is ignored; decode re-asserts it after the stall.
  5. i_jump = 1: IF/ID <= {mem[PC], PC+4}; PC <= i_jump_address. The fetched word is the delay slot.
  6. Otherwise: IF/ID <= {mem[PC], PC+4}; PC <= PC+4.
- Arithmetic:
  - PC+4 is 32-bit and wraps at 2^32.
  - i_jump_address is used as-is; bits [1:0] are not masked, and memory indexing drops them.
- Latency:
  - One cycle from PC to IF/ID.
  - A jump asserted in cycle n puts the target instruction into IF/ID at edge n+2.
- Halt:
  - o_halted is sticky until reset.
  - No instruction after HALT ever reaches IF/ID.
- State: a two-state FSM, RUN and HALTED.
  - RUN -> HALTED on rule 3.
  - HALTED -> RUN only on reset.
- Single-step: pulsing i_enable for one cycle advances exactly one fetch.
- o_pc_current always reflects the PC register.

Decomposition:
- Shared package mips_pkg holds:
  - INSTR_NOP = 32'h00000000
  - INSTR_HALT = 32'hFFFFFFFF
  - PC_INCREMENT = 4
  - state encoding ST_RUN / ST_HALTED
  - RESET_PC default
- Sub-module instruction_memory (params DEPTH, WIDTH = 32; ports i_clk, i_write_en, i_write_addr, i_write_data, i_read_addr, o_read_data).
  - Async read, sync write, no reset.
- instruction_fetch holds only the PC, IF/ID latch, FSM and priority logic.

Test Plan:
1. Load words 0x20010005, 0x20020007, 0x00221820 at byte addresses 0, 4, 8; reset; i_enable = 1.
   - Successive edges give o_instruction = 0x20010005, 0x20020007, 0x00221820.
   - o_pc = 4, 8, 12.
2. Sequential fetch from PC 0x10, then i_stall = 1 for 2 cycles.
   - o_instruction, o_pc and o_pc_current hold for 2 cycles, then resume at 0x14.
3. At PC = 0x08, i_jump = 1 with i_jump_address = 0x40 for one cycle.
   - Next IF/ID = {mem[0x08], 0x0C}.
   - Following IF/ID = {mem[0x40], 0x44}.
4. Same as test 3 but with i_stall = 1 together with i_jump.
   - No redirect; PC stays 0x08.
   - Assert i_jump alone next cycle: redirect to 0x40 as in test 3.
5. Place 0xFFFFFFFF at 0x0C; drive i_halt = 1 while it sits in IF/ID.
   - o_halted = 1 from the next edge.
   - IF/ID stays 0xFFFFFFFF and PC stays 0x10 for 20 cycles.
   - i_halt = 0 and i_enable toggling have no effect.
   - Assert i_reset asynchronously, mid-cycle: PC = 0, o_instruction = 0 and o_halted = 0 immediately, with no clock edge; memory is retained.
6. Write IMEM_DEPTH*4 + 8 = 0x408 with 0xABCD0001 in the same cycle the PC fetches 0x08.
   - Captured IF/ID holds the old mem[0x08].
   - After a later refetch of 0x08, via jump, IF/ID holds 0xABCD0001.
